// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver: FSM state encoding and
// don't-care fill modes for the excitation table.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int DC_MIN  = 0;
    localparam int DC_COMP = 1;

endpackage

// File: rtl/jk_excite.sv
// Single-bit JK excitation: current state q and target t to the J/K pair
// that moves a JK flip-flop from q to t on the next edge.
module jk_excite
    import jk_pkg::*;
#(
    parameter int DC_FILL = DC_MIN
) (
    input  logic q,
    input  logic t,
    output logic j,
    output logic k
);

    // NOTE: both outputs are assigned on every path so no latch is inferred.
    always_comb begin
        if (DC_FILL == DC_COMP) begin
            j = t;
            k = ~t;
        end else begin
            j = ~q & t;
            k = q & ~t;
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives J/K onto a JK flip-flop bank to reach a requested next state, then
// reads the bank back one edge later and flags/counts any bits that missed.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DC_FILL = DC_MIN,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] mismatch,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    state_t           state;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] cnt_base;

    for (genvar i = 0; i < WIDTH; i++) begin : g_excite
        jk_excite #(.DC_FILL(DC_FILL)) u_excite (
            .q (q_in[i]),
            .t (tgt_data[i]),
            .j (j_next[i]),
            .k (k_next[i])
        );
    end

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign diff      = q_in ^ tgt_r;
    // A clear in the same cycle as a failing check restarts the count from zero.
    assign cnt_base  = err_clr ? '0 : err_cnt;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, and later assignments in the block win.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            J        <= '0;
            K        <= '0;
            err      <= 1'b0;
            mismatch <= '0;
            err_cnt  <= '0;
            tgt_r    <= '0;
        end else begin
            err <= 1'b0;
            if (err_clr) begin
                err_cnt  <= '0;
                mismatch <= '0;
            end
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_r <= tgt_data;
                        J     <= j_next;
                        K     <= k_next;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The bank captures J/K at this edge; release to hold afterwards.
                    J     <= '0;
                    K     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    mismatch <= diff;
                    err      <= |diff;
                    if ((|diff) && (cnt_base != '1)) begin
                        err_cnt <= cnt_base + CNT_W'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench: three driver variants (minimal fill, complementary fill,
// 2-bit counter) share stimulus, each driving its own modelled JK bank.
module tb_jk_excitation_driver;

    typedef struct {
        logic [3:0] mism;
        logic       err;
        logic [7:0] c0;
        logic [1:0] c2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bank_rst = 1'b1;
    logic       tgt_valid = 1'b0;
    logic [3:0] tgt_data = '0;
    logic       err_clr = 1'b0;
    logic [3:0] stuck = '0;

    logic [3:0] q0, q1, q2;
    logic [3:0] J0, K0, J1, K1, J2, K2;
    logic [3:0] mm0, mm1, mm2;
    logic       rdy0, rdy1, rdy2, busy0, busy1, busy2, err0, err1, err2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_c0 = '0;
    logic [1:0] exp_c2 = '0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Behavioural JK bank per driver; bits in 'stuck' are held at 0.
    always @(posedge clk) begin
        q0 <= bank_rst ? 4'h0 : (((J0 & ~q0) | (~K0 & q0)) & ~stuck);
        q1 <= bank_rst ? 4'h0 : (((J1 & ~q1) | (~K1 & q1)) & ~stuck);
        q2 <= bank_rst ? 4'h0 : (((J2 & ~q2) | (~K2 & q2)) & ~stuck);
    end

    jk_excitation_driver #(.WIDTH(4), .DC_FILL(0), .CNT_W(8)) dut (
        .CLK(clk), .RST(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy0), .tgt_data(tgt_data),
        .q_in(q0), .J(J0), .K(K0), .busy(busy0), .err(err0), .mismatch(mm0),
        .err_cnt(cnt0), .err_clr(err_clr));

    jk_excitation_driver #(.WIDTH(4), .DC_FILL(1), .CNT_W(8)) dut_comp (
        .CLK(clk), .RST(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy1), .tgt_data(tgt_data),
        .q_in(q1), .J(J1), .K(K1), .busy(busy1), .err(err1), .mismatch(mm1),
        .err_cnt(cnt1), .err_clr(err_clr));

    jk_excitation_driver #(.WIDTH(4), .DC_FILL(0), .CNT_W(2)) dut_sat (
        .CLK(clk), .RST(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy2), .tgt_data(tgt_data),
        .q_in(q2), .J(J2), .K(K2), .busy(busy2), .err(err2), .mismatch(mm2),
        .err_cnt(cnt2), .err_clr(err_clr));

    // One full transaction; expected J/K come from the caller, expected
    // check results are queued at accept and popped when err/mismatch land.
    task automatic send(input string name, input logic [3:0] tgt,
                        input logic [3:0] ej, input logic [3:0] ek,
                        input logic [3:0] ejc, input logic [3:0] ekc,
                        input bit clr_in_check);
        exp_t e;
        int   waited = 0;
        while (!rdy0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!rdy0) begin
            failures++;
            $display("FAIL %s ready_timeout got=%b exp=1", name, rdy0);
            return;
        end
        tgt_valid = 1'b1;
        tgt_data  = tgt;
        e.mism = tgt & stuck;
        e.err  = |(tgt & stuck);
        if (clr_in_check) begin
            exp_c0 = e.err ? 8'd1 : 8'd0;
            exp_c2 = e.err ? 2'd1 : 2'd0;
        end else if (e.err) begin
            exp_c0 = (exp_c0 == 8'hFF) ? 8'hFF : exp_c0 + 8'd1;
            exp_c2 = (exp_c2 == 2'd3) ? 2'd3 : exp_c2 + 2'd1;
        end
        e.c0 = exp_c0;
        e.c2 = exp_c2;
        sb.push_back(e);

        @(negedge clk);  // DRIVE
        tgt_valid = 1'b0;
        checks++; if (J0 !== ej)  begin failures++; $display("FAIL %s drive_J got=%b exp=%b", name, J0, ej); end
        checks++; if (K0 !== ek)  begin failures++; $display("FAIL %s drive_K got=%b exp=%b", name, K0, ek); end
        checks++; if (J1 !== ejc) begin failures++; $display("FAIL %s drive_J_comp got=%b exp=%b", name, J1, ejc); end
        checks++; if (K1 !== ekc) begin failures++; $display("FAIL %s drive_K_comp got=%b exp=%b", name, K1, ekc); end
        checks++; if (busy0 !== 1'b1 || rdy0 !== 1'b0) begin failures++; $display("FAIL %s drive_state busy=%b ready=%b exp busy=1 ready=0", name, busy0, rdy0); end

        @(negedge clk);  // CHECK
        if (clr_in_check) err_clr = 1'b1;
        checks++; if (J0 !== 4'h0 || K0 !== 4'h0) begin failures++; $display("FAIL %s check_JK got=%b/%b exp=0000/0000", name, J0, K0); end
        checks++; if (busy0 !== 1'b1 || err0 !== 1'b0) begin failures++; $display("FAIL %s check_state busy=%b err=%b exp busy=1 err=0", name, busy0, err0); end

        @(negedge clk);  // result visible, back in IDLE
        err_clr = 1'b0;
        e = sb.pop_front();
        checks++; if (err0 !== e.err)  begin failures++; $display("FAIL %s err got=%b exp=%b", name, err0, e.err); end
        checks++; if (mm0 !== e.mism)  begin failures++; $display("FAIL %s mismatch got=%b exp=%b", name, mm0, e.mism); end
        checks++; if (cnt0 !== e.c0)   begin failures++; $display("FAIL %s err_cnt got=%0d exp=%0d", name, cnt0, e.c0); end
        checks++; if (err1 !== e.err || mm1 !== e.mism || cnt1 !== e.c0) begin failures++; $display("FAIL %s comp_result err=%b mm=%b cnt=%0d exp %b %b %0d", name, err1, mm1, cnt1, e.err, e.mism, e.c0); end
        checks++; if (cnt2 !== e.c2)   begin failures++; $display("FAIL %s err_cnt_sat got=%0d exp=%0d", name, cnt2, e.c2); end
        checks++; if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL %s idle_state ready=%b busy=%b exp 1/0", name, rdy0, busy0); end

        @(negedge clk);
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL %s err_pulse_width got=%b exp=0", name, err0); end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bank_rst = 1'b0;
        checks++; if (J0 !== 4'h0 || K0 !== 4'h0) begin failures++; $display("FAIL reset_JK got=%b/%b exp=0000/0000", J0, K0); end
        checks++; if (err0 !== 1'b0 || cnt0 !== 8'd0 || mm0 !== 4'h0) begin failures++; $display("FAIL reset_err err=%b cnt=%0d mm=%b exp 0/0/0000", err0, cnt0, mm0); end
        checks++; if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL reset_state ready=%b busy=%b exp 1/0", rdy0, busy0); end
    endtask

    task automatic test_basic;
        send("set_1010", 4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b0101, 1'b0);
        send("move_0110", 4'b0110, 4'b0100, 4'b1000, 4'b0110, 4'b1001, 1'b0);
    endtask

    task automatic test_stuck;
        stuck = 4'b0001;
        // bank 0110 -> 0001 with bit0 stuck: bank lands at 0000
        send("stuck_bit0", 4'b0001, 4'b0001, 4'b0110, 4'b0001, 4'b1110, 1'b0);
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 3; i++)
            send("saturate", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 1'b0);
    endtask

    task automatic test_clr_same_cycle;
        send("clr_with_fail", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 1'b1);
    endtask

    task automatic test_clear;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_c0 = '0;
        exp_c2 = '0;
        checks++; if (cnt0 !== 8'd0 || mm0 !== 4'h0 || cnt2 !== 2'd0) begin failures++; $display("FAIL clear cnt=%0d mm=%b cnt_sat=%0d exp 0/0000/0", cnt0, mm0, cnt2); end
        checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL clear_fsm ready=%b exp=1", rdy0); end
    endtask

    task automatic test_reset_mid;
        stuck = 4'b0000;
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        @(negedge clk);  // DRIVE
        tgt_valid = 1'b0;
        rst = 1'b1;
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL reset_mid_accept busy=%b exp=1", busy0); end
        @(negedge clk);
        rst = 1'b0;
        exp_c0 = '0;
        exp_c2 = '0;
        checks++; if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL reset_mid_state ready=%b busy=%b exp 1/0", rdy0, busy0); end
        checks++; if (J0 !== 4'h0 || K0 !== 4'h0 || cnt0 !== 8'd0) begin failures++; $display("FAIL reset_mid_regs J=%b K=%b cnt=%0d exp 0000/0000/0", J0, K0, cnt0); end
        @(negedge clk);
        checks++; if (err0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL reset_mid_no_check err=%b busy=%b exp 0/0", err0, busy0); end
    endtask

    task automatic test_back_to_back;
        int accepts = 0;
        tgt_valid = 1'b1;
        tgt_data  = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            if (rdy0) accepts++;
            @(negedge clk);
        end
        tgt_valid = 1'b0;
        checks++; if (accepts !== 3) begin failures++; $display("FAIL back_to_back_accepts got=%0d exp=3", accepts); end
        checks++; if (err0 !== 1'b0 || cnt0 !== 8'd0 || rdy0 !== 1'b1) begin failures++; $display("FAIL back_to_back_end err=%b cnt=%0d ready=%b exp 0/0/1", err0, cnt0, rdy0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuck();
        test_saturate();
        test_clr_same_cycle();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
